quad_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 43 ++++
 rtl/quad_sat_counter.sv | 51 +++++
 rtl/quad_decoder.sv | 140 ++++++++++++++
 tb/tb_quad_decoder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : quad_pkg
//  Purpose  : Shared quadrature Gray-code constants, transition codes and the
//             transition classifier used by the quadrature decoder.
//  Revision : 1.0 - initial release
// ============================================================================
package quad_pkg;

    // Gray states listed as {A,B}; clockwise rotation walks S00->S01->S11->S10.
    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S11 = 2'b11;
    localparam logic [1:0] S10 = 2'b10;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        INC     = 2'd1,
        DEC     = 2'd2,
        ILLEGAL = 2'd3
    } trans_e;

    // Classify the move from the last accepted state to the current sample.
    // Any move other than a single clockwise/counter-clockwise neighbour step
    // means both channels changed together.
    function automatic trans_e gray_step(input logic [1:0] prev, input logic [1:0] cur);
        trans_e t;
        t = ILLEGAL;
        if (prev == cur) begin
            t = HOLD;
        end else begin
            case (prev)
                S00: t = (cur == S01) ? INC : ((cur == S10) ? DEC : ILLEGAL);
                S01: t = (cur == S11) ? INC : ((cur == S00) ? DEC : ILLEGAL);
                S11: t = (cur == S10) ? INC : ((cur == S01) ? DEC : ILLEGAL);
                S10: t = (cur == S00) ? INC : ((cur == S11) ? DEC : ILLEGAL);
            endcase
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : quad_sat_counter
//  Purpose  : Up/down counter that saturates at POS_MIN/POS_MAX; holds the
//             cursor coordinate for one axis.
//  Revision : 1.0 - initial release
// ============================================================================
module quad_sat_counter #(
    parameter int POS_WIDTH = 10,
    parameter int POS_MIN   = 0,
    parameter int POS_MAX   = 639,
    parameter int POS_INIT  = 320
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [POS_WIDTH-1:0] position_o
);

    localparam logic [POS_WIDTH-1:0] c_pos_min  = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0] c_pos_max  = POS_WIDTH'(POS_MAX);
    localparam logic [POS_WIDTH-1:0] c_pos_init = POS_WIDTH'(POS_INIT);
    localparam logic [POS_WIDTH-1:0] c_pos_one  = POS_WIDTH'(1);

    logic [POS_WIDTH-1:0] pos_q;
    logic [POS_WIDTH-1:0] pos_d;

    // Next position: bound is checked before stepping so the value never wraps.
    always_comb begin
        pos_d = pos_q;
        if (inc_i && (pos_q < c_pos_max)) begin
            pos_d = pos_q + c_pos_one;
        end else if (dec_i && (pos_q > c_pos_min)) begin
            pos_d = pos_q - c_pos_one;
        end
    end

    // Position register, reloaded with the centre value on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q <= c_pos_init;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign position_o = pos_q;

endmodule
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : quad_decoder
//  Purpose  : Converts a debounced quadrature pair into detent step pulses,
//             a direction flag, an illegal-transition pulse and a saturating
//             cursor coordinate.
//  Revision : 1.0 - initial release
// ============================================================================
module quad_decoder
    import quad_pkg::*;
#(
    parameter int POS_WIDTH         = 10,
    parameter int POS_MIN           = 0,
    parameter int POS_MAX           = 639,
    parameter int POS_INIT          = 320,
    parameter int COUNTS_PER_DETENT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Ain,
    input  logic                 Bin,
    output logic                 step,
    output logic                 dir,
    output logic [POS_WIDTH-1:0] position,
    output logic                 err
);

    localparam int SUB_W = $clog2(COUNTS_PER_DETENT) + 2;
    localparam logic signed [SUB_W-1:0] c_sub_top = SUB_W'(COUNTS_PER_DETENT - 1);
    localparam logic signed [SUB_W-1:0] c_sub_bot = -c_sub_top;
    localparam logic signed [SUB_W-1:0] c_sub_one = SUB_W'(1);

    logic [1:0]              ab_q;
    logic [1:0]              st_q;
    logic [1:0]              st_d;
    logic signed [SUB_W-1:0] sub_q;
    logic signed [SUB_W-1:0] sub_d;
    logic                    init_q;
    logic                    step_q;
    logic                    step_d;
    logic                    dir_q;
    logic                    dir_d;
    logic                    err_q;
    logic                    err_d;
    logic                    cnt_inc;
    logic                    cnt_dec;
    trans_e                  trans;

    assign trans = gray_step(st_q, ab_q);

    // Decode the sampled pair against the last accepted state. A detent is
    // recognised when the sub-count is one short of the limit and moves again.
    always_comb begin
        st_d    = st_q;
        sub_d   = sub_q;
        step_d  = 1'b0;
        dir_d   = dir_q;
        err_d   = 1'b0;
        cnt_inc = 1'b0;
        cnt_dec = 1'b0;
        if (init_q) begin
            // Adopt the resting state of the input pair as the reference; the
            // pair being captured on this edge is used so a non-zero rest is
            // never a move.
            st_d = {Ain, Bin};
        end else begin
            case (trans)
                HOLD: begin
                end
                INC: begin
                    st_d = ab_q;
                    if (sub_q == c_sub_top) begin
                        sub_d   = '0;
                        step_d  = 1'b1;
                        dir_d   = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        sub_d = sub_q + c_sub_one;
                    end
                end
                DEC: begin
                    st_d = ab_q;
                    if (sub_q == c_sub_bot) begin
                        sub_d   = '0;
                        step_d  = 1'b1;
                        dir_d   = 1'b0;
                        cnt_dec = 1'b1;
                    end else begin
                        sub_d = sub_q - c_sub_one;
                    end
                end
                ILLEGAL: begin
                    st_d  = ab_q;
                    sub_d = '0;
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Sample the pins every edge and commit decoder state and output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_q   <= S00;
            st_q   <= S00;
            sub_q  <= '0;
            init_q <= 1'b1;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ab_q   <= {Ain, Bin};
            st_q   <= st_d;
            sub_q  <= sub_d;
            init_q <= 1'b0;
            step_q <= step_d;
            dir_q  <= dir_d;
            err_q  <= err_d;
        end
    end

    quad_sat_counter #(
        .POS_WIDTH (POS_WIDTH),
        .POS_MIN   (POS_MIN),
        .POS_MAX   (POS_MAX),
        .POS_INIT  (POS_INIT)
    ) u_pos (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (cnt_inc),
        .dec_i      (cnt_dec),
        .position_o (position)
    );

    assign step = step_q;
    assign dir  = dir_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_decoder
//  Purpose  : Self-checking bench for quad_decoder; three instances differing
//             only in POS_INIT share one input stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quad_decoder;

    localparam int CPD     = 4;
    localparam int POS_MIN = 0;
    localparam int POS_MAX = 639;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       Ain   = 1'b0;
    logic       Bin   = 1'b0;
    logic [2:0] step_o;
    logic [2:0] dir_o;
    logic [2:0] err_o;
    logic [9:0] pos_o [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    quad_decoder #(.POS_WIDTH(10), .POS_MIN(0), .POS_MAX(639), .POS_INIT(320), .COUNTS_PER_DETENT(CPD)) u_dut (
        .clk(clk), .reset(reset), .Ain(Ain), .Bin(Bin),
        .step(step_o[0]), .dir(dir_o[0]), .position(pos_o[0]), .err(err_o[0]));
    quad_decoder #(.POS_WIDTH(10), .POS_MIN(0), .POS_MAX(639), .POS_INIT(638), .COUNTS_PER_DETENT(CPD)) u_hi (
        .clk(clk), .reset(reset), .Ain(Ain), .Bin(Bin),
        .step(step_o[1]), .dir(dir_o[1]), .position(pos_o[1]), .err(err_o[1]));
    quad_decoder #(.POS_WIDTH(10), .POS_MIN(0), .POS_MAX(639), .POS_INIT(1), .COUNTS_PER_DETENT(CPD)) u_lo (
        .clk(clk), .reset(reset), .Ain(Ain), .Bin(Bin),
        .step(step_o[2]), .dir(dir_o[2]), .position(pos_o[2]), .err(err_o[2]));

    // ------------------------------------------------------------------
    // Reference model: encoder angle as a phase 0..3, movement as the phase
    // difference modulo 4, a signed integer accumulator and clamped integers.
    // ------------------------------------------------------------------
    logic [1:0] m_ab;
    logic [1:0] m_st;
    int         m_sub;
    bit         m_init;
    bit         m_step;
    bit         m_err;
    bit         m_dir;
    int         m_pos [3];

    function automatic int init_of(input int k);
        case (k)
            0:       return 320;
            1:       return 638;
            default: return 1;
        endcase
    endfunction

    function automatic int phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int p);
        case (p % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    always @(posedge clk) begin : p_model
        int d;
        if (reset) begin
            m_ab = 2'b00; m_st = 2'b00; m_sub = 0; m_init = 1'b1;
            m_step = 1'b0; m_err = 1'b0; m_dir = 1'b0;
            for (int k = 0; k < 3; k++) m_pos[k] = init_of(k);
        end else begin
            m_step = 1'b0;
            m_err  = 1'b0;
            if (m_init) begin
                m_st   = {Ain, Bin};
                m_init = 1'b0;
            end else begin
                d = (phase(m_ab) - phase(m_st) + 4) % 4;
                if (d == 2) begin
                    m_err = 1'b1;
                    m_sub = 0;
                end else if (d != 0) begin
                    m_sub = m_sub + ((d == 1) ? 1 : -1);
                    if (m_sub == CPD) begin
                        m_step = 1'b1; m_dir = 1'b1; m_sub = 0;
                        for (int k = 0; k < 3; k++)
                            m_pos[k] = (m_pos[k] + 1 > POS_MAX) ? POS_MAX : m_pos[k] + 1;
                    end else if (m_sub == -CPD) begin
                        m_step = 1'b1; m_dir = 1'b0; m_sub = 0;
                        for (int k = 0; k < 3; k++)
                            m_pos[k] = (m_pos[k] - 1 < POS_MIN) ? POS_MIN : m_pos[k] - 1;
                    end
                end
                m_st = m_ab;
            end
            m_ab = {Ain, Bin};
        end
    end

    // Drive the pair, let one rising edge pass, return on the falling edge.
    task automatic tick(input logic [1:0] ab);
        {Ain, Bin} = ab;
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] ab);
        reset = 1'b1;
        tick(ab);
        tick(ab);
        reset = 1'b0;
        tick(ab);
        tick(ab);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(2'b11);
        tick(2'b11);
        n_cmp++;
        if ({step_o[0], err_o[0], dir_o[0]} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags got=%b want=000", {step_o[0], err_o[0], dir_o[0]});
        end
        n_cmp++;
        if (pos_o[0] !== 10'd320 || pos_o[1] !== 10'd638 || pos_o[2] !== 10'd1) begin
            n_bad++; $display("FAIL reset_pos got=%0d/%0d/%0d want=320/638/1", pos_o[0], pos_o[1], pos_o[2]);
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(2'b11);
            n_cmp++;
            if (step_o[0] !== 1'b0 || err_o[0] !== 1'b0 || pos_o[0] !== 10'd320) begin
                n_bad++; $display("FAIL rest11 cyc=%0d got step=%b err=%b pos=%0d want 0/0/320",
                                  i, step_o[0], err_o[0], pos_o[0]);
            end
        end
    endtask

    task automatic test_cw();
        logic [1:0] seq [4];
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        do_reset(2'b00);
        for (int i = 0; i < 16; i++) begin
            tick(seq[i / 4]);
            n_cmp++;
            if (step_o[0] !== (i == 13) || err_o[0] !== 1'b0) begin
                n_bad++; $display("FAIL cw_pulse cyc=%0d got step=%b err=%b want step=%b err=0",
                                  i, step_o[0], err_o[0], (i == 13));
            end
        end
        n_cmp++;
        if (dir_o[0] !== 1'b1 || pos_o[0] !== 10'd321) begin
            n_bad++; $display("FAIL cw_final got dir=%b pos=%0d want 1/321", dir_o[0], pos_o[0]);
        end
    endtask

    task automatic test_ccw();
        logic [1:0] seq [4];
        int steps;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        steps = 0;
        do_reset(2'b00);
        for (int i = 0; i < 17; i++) begin
            tick(seq[(i / 2) % 4]);
            steps += int'(step_o[0]);
        end
        tick(2'b00);
        steps += int'(step_o[0]);
        n_cmp++;
        if (steps != 2 || dir_o[0] !== 1'b0 || pos_o[0] !== 10'd318) begin
            n_bad++; $display("FAIL ccw got steps=%0d dir=%b pos=%0d want 2/0/318", steps, dir_o[0], pos_o[0]);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] seq [3];
        int errs;
        int steps;
        seq = '{2'b10, 2'b00, 2'b01};
        errs = 0;
        steps = 0;
        do_reset(2'b00);
        tick(2'b11);
        n_cmp++;
        if (err_o[0] !== 1'b0) begin
            n_bad++; $display("FAIL illegal_early got err=%b want 0", err_o[0]);
        end
        tick(2'b11);
        n_cmp++;
        if (err_o[0] !== 1'b1) begin
            n_bad++; $display("FAIL illegal_pulse got err=%b want 1", err_o[0]);
        end
        for (int i = 0; i < 6; i++) begin
            tick(seq[i / 2]);
            errs  += int'(err_o[0]);
            steps += int'(step_o[0]);
        end
        n_cmp++;
        if (errs != 0 || steps != 0) begin
            n_bad++; $display("FAIL illegal_partial got errs=%0d steps=%0d want 0/0", errs, steps);
        end
        tick(2'b11);
        tick(2'b11);
        n_cmp++;
        if (step_o[0] !== 1'b1 || dir_o[0] !== 1'b1 || pos_o[0] !== 10'd321) begin
            n_bad++; $display("FAIL illegal_4th got step=%b dir=%b pos=%0d want 1/1/321",
                              step_o[0], dir_o[0], pos_o[0]);
        end
    endtask

    task automatic test_reversal();
        logic [1:0] seq [4];
        int flags;
        seq = '{2'b01, 2'b11, 2'b01, 2'b00};
        flags = 0;
        do_reset(2'b00);
        for (int i = 0; i < 10; i++) begin
            tick(seq[(i < 8) ? i / 2 : 3]);
            flags += int'(step_o[0]) + int'(err_o[0]);
        end
        n_cmp++;
        if (flags != 0 || pos_o[0] !== 10'd320) begin
            n_bad++; $display("FAIL reversal got pulses=%0d pos=%0d want 0/320", flags, pos_o[0]);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] seq [4];
        int steps;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        steps = 0;
        do_reset(2'b00);
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) begin
                tick(seq[i / 2]);
                steps += int'(step_o[1]);
            end
            n_cmp++;
            if (pos_o[1] !== 10'd639 || pos_o[0] !== 10'(321 + d) || dir_o[1] !== 1'b1) begin
                n_bad++; $display("FAIL sat_max det=%0d got hi=%0d mid=%0d dir=%b want 639/%0d/1",
                                  d, pos_o[1], pos_o[0], dir_o[1], 321 + d);
            end
        end
        n_cmp++;
        if (steps != 3) begin
            n_bad++; $display("FAIL sat_steps got=%0d want=3", steps);
        end
        tick(2'b01);
        tick(2'b11);
        reset = 1'b1;
        tick(2'b11);
        reset = 1'b0;
        steps = 0;
        for (int i = 0; i < 6; i++) begin
            tick(2'b11);
            steps += int'(step_o[1]) + int'(err_o[1]);
        end
        n_cmp++;
        if (pos_o[1] !== 10'd638 || pos_o[0] !== 10'd320 || steps != 0) begin
            n_bad++; $display("FAIL mid_reset got hi=%0d mid=%0d pulses=%0d want 638/320/0",
                              pos_o[1], pos_o[0], steps);
        end
    endtask

    task automatic test_min_sat();
        logic [1:0] seq [4];
        int steps;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        steps = 0;
        do_reset(2'b00);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                tick(seq[i / 2]);
                steps += int'(step_o[2]);
            end
            n_cmp++;
            if (pos_o[2] !== 10'd0 || dir_o[2] !== 1'b0) begin
                n_bad++; $display("FAIL sat_min det=%0d got pos=%0d dir=%b want 0/0", d, pos_o[2], dir_o[2]);
            end
        end
        n_cmp++;
        if (steps != 2) begin
            n_bad++; $display("FAIL sat_min_steps got=%0d want=2", steps);
        end
    endtask

    task automatic test_random();
        int p;
        int r;
        p = 0;
        do_reset(2'b00);
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            reset = 1'b0;
            if (r < 38)      p = p + 1;
            else if (r < 62) p = p + 3;
            else if (r < 66) p = p + 2;
            else if (r < 68) reset = 1'b1;
            tick(ab_of(p));
            n_cmp++;
            if (step_o[0] !== m_step || err_o[0] !== m_err || dir_o[0] !== m_dir) begin
                n_bad++; $display("FAIL rand_flags cyc=%0d got s/e/d=%b%b%b want %b%b%b",
                                  i, step_o[0], err_o[0], dir_o[0], m_step, m_err, m_dir);
            end
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (pos_o[k] !== 10'(m_pos[k]) || step_o[k] !== m_step) begin
                    n_bad++; $display("FAIL rand_pos inst=%0d cyc=%0d got pos=%0d step=%b want %0d/%b",
                                      k, i, pos_o[k], step_o[k], m_pos[k], m_step);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cw();
        test_ccw();
        test_illegal();
        test_reversal();
        test_saturation();
        test_min_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
